exe_pipe: RTL and testbench
===========================

// Module: exe_pipe
// PURPOSE
// - Registered, parametrised execute stage: ALU ops, PC+imm adder, branch resolution, iterative DIV/REM.
// - Sits between decode and memory stages; valid/ready handshake both sides; stalls upstream while dividing.
// - Result, jump address and jump decision are registered (1-cycle latency, non-divide ops).
// PARAMETERS
// - XLEN    32  datapath width (>=8, even)
// - DIV_EN  1   1: iterative divider present; 0: divide ops return 0, latency 1
// - IALIGN  32  16 or 32; taken-jump misalignment check granularity
// PORTS
// - i_clk             in   1     clock, rising edge
// - i_rst_n           in   1     reset, asynchronous, active-low
// - i_flush           in   1     kill in-flight op and output register
// - i_valid           in   1     upstream op valid
// - o_ready           out  1     stage can accept op
// - i_alu_input_sel   in   1     0: op2=rs2, 1: op2=immed
// - i_alu_op_sel      in   3     ALU operation (funct3 encoding)
// - i_alu_sub_sel     in   1     subtract on add op
// - i_alu_sign_sel    in   1     unsigned compare
// - i_alu_arith_sel   in   1     arithmetic right shift
// - i_div_sel         in   1     op is DIV/DIVU/REM/REMU (selected by i_funct3)
// - i_jump_sel        in   1     op is branch/jump
// - i_jump_type_sel   in   1     0: target=pc+imm, 1: target=ALU result, bit0 cleared
// - i_funct3          in   3     branch condition / divide variant
// - i_rs1, i_rs2      in   XLEN  register operands
// - i_immed, i_pc     in   XLEN  immediate, instruction PC
// - o_valid           out  1     output register holds a result
// - i_ready           in   1     downstream accepts
// - o_result          out  XLEN  ALU or divider result
// - o_pc_immed        out  XLEN  pc+imm (wraps mod 2^XLEN)
// - o_jump_addr       out  XLEN  jump target
// - o_jump_taken      out  1     jump/branch taken (qualified by o_valid)
// - o_misalign        out  1     taken target not IALIGN-aligned (IALIGN=32: addr[1]!=0)
// BEHAVIOUR
// - Reset: o_valid=0, all data outputs 0, FSM=IDLE, o_ready=1 after reset release.
// - Accept = i_valid & o_ready; o_ready = (state==IDLE) & (~o_valid | i_ready).
// - Non-divide op: outputs loaded on accept edge, o_valid=1 next cycle.
// - Output hold: o_valid & ~i_ready -> all outputs stable; cleared on i_ready when no new result.
// - Branch: rs1 vs rs2 (caller sets alu_input_sel=0); funct3 000 EQ,001 NE,100 LT,101 GE,110 LTU,111 GEU; others not-taken.
// - Jump (jump_sel, no branch funct3 check when jump_type_sel=1): taken=1.
// - Divide FSM: IDLE -accept&div-> DIV (XLEN cycles, restoring, 1 bit/cycle) -> DONE (load outputs) -> IDLE.
//   Divide latency accept->o_valid = XLEN+2 cycles; o_ready=0 throughout DIV/DONE.
// - funct3 100 DIV,101 DIVU,110 REM,111 REMU; signed ops: operate on magnitudes, fix signs in DONE.
// - Divide by zero: quotient all-ones, remainder = rs1. Overflow (-2^(XLEN-1) / -1): quotient=rs1, rem=0.
// - i_flush: next edge o_valid=0, FSM->IDLE, divider discarded; flush wins over simultaneous accept.
// - Divide with DIV_EN=0: o_result=0, normal 1-cycle latency.
// - Mid-operation async reset: everything returns to reset values immediately.
// STRUCTURE
// - Shared package: funct3 branch/divide encodings, FSM state encodings, ALU op codes.
// - Sub-module exe_div_iter (XLEN param): start/done handshake, restoring divider, sign fix-up.
// - ALU and adder inline, width XLEN.
// TESTING
// - ADD rs1=5, immed=7, alu_input_sel=1 -> o_result=12 one cycle after accept, o_valid=1.
// - BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 -> o_jump_taken=1, o_jump_addr=0x120; BLTU same -> taken=0.
// - DIV rs1=-7, rs2=2 -> result=-3 at accept+34 cycles (XLEN=32), o_ready=0 meanwhile; REM -> -1.
// - DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0; DIV same -> 0x80000000.
// - i_ready=0 for 3 cycles with o_valid=1 -> outputs stable, o_ready=0; i_flush mid-DIV -> o_valid stays 0, o_ready=1 next cycle.
// - JALR rs1=0x1001, imm=2, jump_type_sel=1 -> addr=0x1002, o_misalign=1 (IALIGN=32), 0 (IALIGN=16).

Source files
------------

// File: rtl/exe_pipe_pkg.sv
// Shared encodings for the execute stage:
// FSM states, ALU ops, branch and divide funct3.
package exe_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] DV_DIV  = 3'b100;
  localparam logic [2:0] DV_DIVU = 3'b101;
  localparam logic [2:0] DV_REM  = 3'b110;
  localparam logic [2:0] DV_REMU = 3'b111;

endpackage

// File: rtl/exe_pipe_if.sv
// Execute stage bus: upstream op + handshake,
// downstream result + handshake, flush.
interface exe_pipe_if #(
  parameter int XLEN = 32
);
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic            i_alu_input_sel;
  logic [2:0]      i_alu_op_sel;
  logic            i_alu_sub_sel;
  logic            i_alu_sign_sel;
  logic            i_alu_arith_sel;
  logic            i_div_sel;
  logic            i_jump_sel;
  logic            i_jump_type_sel;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [XLEN-1:0] i_immed;
  logic [XLEN-1:0] i_pc;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [XLEN-1:0] o_pc_immed;
  logic [XLEN-1:0] o_jump_addr;
  logic            o_jump_taken;
  logic            o_misalign;

  modport master (
    output i_flush, i_valid, i_alu_input_sel,
    output i_alu_op_sel, i_alu_sub_sel,
    output i_alu_sign_sel, i_alu_arith_sel,
    output i_div_sel, i_jump_sel, i_jump_type_sel,
    output i_funct3, i_rs1, i_rs2, i_immed, i_pc,
    output i_ready,
    input  o_ready, o_valid, o_result, o_pc_immed,
    input  o_jump_addr, o_jump_taken, o_misalign
  );

  modport slave (
    input  i_flush, i_valid, i_alu_input_sel,
    input  i_alu_op_sel, i_alu_sub_sel,
    input  i_alu_sign_sel, i_alu_arith_sel,
    input  i_div_sel, i_jump_sel, i_jump_type_sel,
    input  i_funct3, i_rs1, i_rs2, i_immed, i_pc,
    input  i_ready,
    output o_ready, o_valid, o_result, o_pc_immed,
    output o_jump_addr, o_jump_taken, o_misalign
  );
endinterface

// File: rtl/exe_pipe_div_iter.sv
// Restoring divider, one quotient bit per cycle,
// on magnitudes with sign fix-up on the way out.
module exe_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic            i_signed,
  input  logic            i_rem,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] r_quo, r_rem, r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_busy, r_neg_q, r_neg_r, r_sel_rem;

  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_q, w_r;

  assign w_a_neg = i_signed & i_a[XLEN-1];
  assign w_b_neg = i_signed & i_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;
  assign w_shift = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_diff  = {r_rem, r_quo[XLEN-1]} - {1'b0, r_div};

  // Load operands on start, then shift-subtract XLEN times
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (i_kill) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo     <= w_a_mag;
      r_rem     <= '0;
      r_div     <= w_b_mag;
      r_cnt     <= CW'(XLEN);
      r_busy    <= 1'b1;
      r_neg_q   <= (w_a_neg ^ w_b_neg) & (|i_b);
      r_neg_r   <= w_a_neg;
      r_sel_rem <= i_rem;
    end else if (r_busy) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift;
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= (r_cnt != CW'(1));
    end
  end

  assign o_last   = r_busy & (r_cnt == CW'(1));
  assign w_q      = r_neg_q ? -r_quo : r_quo;
  assign w_r      = r_neg_r ? -r_rem : r_rem;
  assign o_result = r_sel_rem ? w_r : w_q;
endmodule

// File: rtl/exe_pipe.sv
// Registered execute stage: ALU, pc+imm, branch
// resolution, iterative divide with upstream stall.
module exe_pipe
  import exe_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DIV_EN = 1,
  parameter int IALIGN = 32
) (
  input logic     i_clk,
  input logic     i_rst_n,
  exe_pipe_if.slave s
);
  localparam int SHW = $clog2(XLEN);

  state_e          r_state, w_state_nxt;
  logic            r_valid, r_taken, r_mis;
  logic [XLEN-1:0] r_result, r_pc_immed, r_jump_addr;

  logic [XLEN-1:0] w_op2, w_sum, w_alu;
  logic [XLEN-1:0] w_pc_immed, w_target, w_div_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_alu_lt, w_cond, w_taken, w_mis;
  logic            w_ready, w_accept, w_div_go;
  logic            w_div_last, w_dv_signed, w_dv_rem;

  assign w_op2   = s.i_alu_input_sel ? s.i_immed : s.i_rs2;
  assign w_shamt = w_op2[SHW-1:0];
  assign w_sum   = s.i_alu_sub_sel ? s.i_rs1 - w_op2
                                   : s.i_rs1 + w_op2;
  assign w_alu_lt =
    (s.i_alu_op_sel == ALU_SLTU || s.i_alu_sign_sel)
      ? (s.i_rs1 < w_op2)
      : ($signed(s.i_rs1) < $signed(w_op2));

  // ALU result mux
  always_comb begin
    w_alu = w_sum;
    unique case (s.i_alu_op_sel)
      ALU_ADD:  w_alu = w_sum;
      ALU_SLL:  w_alu = s.i_rs1 << w_shamt;
      ALU_SLT,
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_alu_lt};
      ALU_XOR:  w_alu = s.i_rs1 ^ w_op2;
      ALU_SR:   w_alu = s.i_alu_arith_sel
        ? XLEN'($signed(s.i_rs1) >>> w_shamt)
        : s.i_rs1 >> w_shamt;
      ALU_OR:   w_alu = s.i_rs1 | w_op2;
      ALU_AND:  w_alu = s.i_rs1 & w_op2;
      default:  w_alu = w_sum;
    endcase
  end

  // Branch condition from funct3, rs1 vs rs2
  always_comb begin
    w_cond = 1'b0;
    case (s.i_funct3)
      BR_EQ:  w_cond = (s.i_rs1 == s.i_rs2);
      BR_NE:  w_cond = (s.i_rs1 != s.i_rs2);
      BR_LT:  w_cond = $signed(s.i_rs1) < $signed(s.i_rs2);
      BR_GE:  w_cond = $signed(s.i_rs1) >= $signed(s.i_rs2);
      BR_LTU: w_cond = s.i_rs1 < s.i_rs2;
      BR_GEU: w_cond = s.i_rs1 >= s.i_rs2;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_immed = s.i_pc + s.i_immed;
  assign w_target   = s.i_jump_type_sel
                      ? {w_alu[XLEN-1:1], 1'b0} : w_pc_immed;
  assign w_taken    = s.i_jump_sel
                      & (s.i_jump_type_sel | w_cond);
  assign w_mis      = w_taken & ((IALIGN == 32)
                      ? w_target[1] : w_target[0]);

  assign w_ready  = (r_state == ST_IDLE)
                    & (~r_valid | s.i_ready);
  assign w_accept = s.i_valid & w_ready & ~s.i_flush;
  assign w_div_go = s.i_div_sel & (DIV_EN != 0);

  assign w_dv_signed = (s.i_funct3 == DV_DIV)
                     | (s.i_funct3 == DV_REM);
  assign w_dv_rem    = (s.i_funct3 == DV_REM)
                     | (s.i_funct3 == DV_REMU);

  if (DIV_EN != 0) begin : g_div
    exe_div_iter #(.XLEN(XLEN)) u_div (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (w_accept & w_div_go),
      .i_kill   (s.i_flush),
      .i_signed (w_dv_signed),
      .i_rem    (w_dv_rem),
      .i_a      (s.i_rs1),
      .i_b      (s.i_rs2),
      .o_last   (w_div_last),
      .o_result (w_div_res)
    );
  end else begin : g_nodiv
    assign w_div_last = 1'b0;
    assign w_div_res  = '0;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; flush always returns to idle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept && w_div_go)
                 w_state_nxt = ST_DIV;
      ST_DIV:  if (w_div_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (s.i_flush) w_state_nxt = ST_IDLE;
  end

  // Output register: load, divide completion, drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_pc_immed  <= '0;
      r_jump_addr <= '0;
      r_taken     <= 1'b0;
      r_mis       <= 1'b0;
    end else if (s.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept && w_div_go) begin
      r_valid     <= 1'b0;
      r_pc_immed  <= w_pc_immed;
      r_jump_addr <= w_target;
      r_taken     <= 1'b0;
      r_mis       <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_result    <= s.i_div_sel ? '0 : w_alu;
      r_pc_immed  <= w_pc_immed;
      r_jump_addr <= w_target;
      r_taken     <= w_taken;
      r_mis       <= w_mis;
    end else if (r_state == ST_DONE) begin
      r_valid  <= 1'b1;
      r_result <= w_div_res;
    end else if (s.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign s.o_ready      = w_ready;
  assign s.o_valid      = r_valid;
  assign s.o_result     = r_result;
  assign s.o_pc_immed   = r_pc_immed;
  assign s.o_jump_addr  = r_jump_addr;
  assign s.o_jump_taken = r_taken;
  assign s.o_misalign   = r_mis;
endmodule

// File: tb/tb_exe_pipe.sv
// Bench for exe_pipe: directed table, corner
// sequences, and random ops against a reference model.
module tb_exe_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_pipe_if #(.XLEN(32)) bus();

  exe_pipe #(.XLEN(32), .DIV_EN(1), .IALIGN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s       (bus.slave)
  );

  typedef struct {
    logic        isel, sub, sgn, arith;
    logic        div, jmp, jt;
    logic [2:0]  op, f3;
    logic [31:0] rs1, rs2, imm, pc;
  } op_t;

  typedef struct {
    logic [31:0] res, addr, pci;
    logic        taken, mis;
  } exp_t;

  typedef struct {
    string nm;
    op_t   o;
    exp_t  e;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic op_t mk_alu(
      logic [2:0] op, logic isel, logic sub, logic sgn,
      logic arith, logic [31:0] rs1, logic [31:0] rs2,
      logic [31:0] imm);
    op_t o = '{default: '0};
    o.op = op; o.isel = isel; o.sub = sub; o.sgn = sgn;
    o.arith = arith; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
    return o;
  endfunction

  function automatic op_t mk_br(
      logic [2:0] f3, logic jt, logic [31:0] rs1,
      logic [31:0] rs2, logic [31:0] imm, logic [31:0] pc);
    op_t o = '{default: '0};
    o.jmp = 1'b1; o.jt = jt; o.isel = jt; o.f3 = f3;
    o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.pc = pc;
    return o;
  endfunction

  function automatic op_t mk_div(logic [2:0] f3,
      logic [31:0] rs1, logic [31:0] rs2);
    op_t o = '{default: '0};
    o.div = 1'b1; o.f3 = f3; o.rs1 = rs1; o.rs2 = rs2;
    return o;
  endfunction

  function automatic exp_t ex(logic [31:0] res,
      logic [31:0] addr, logic [31:0] pci,
      logic taken, logic mis);
    exp_t e;
    e.res = res; e.addr = addr; e.pci = pci;
    e.taken = taken; e.mis = mis;
    return e;
  endfunction

  // Reference model: plain arithmetic from the ISA rules
  function automatic exp_t model(op_t o);
    exp_t e;
    logic [31:0] a, b, q, r;
    int sh;
    logic lt, cond;
    a = o.rs1;
    b = o.isel ? o.imm : o.rs2;
    sh = int'(b[4:0]);
    case (o.op)
      3'd0: e.res = o.sub ? a - b : a + b;
      3'd1: e.res = a << sh;
      3'd2, 3'd3: begin
        lt = (o.op == 3'd3 || o.sgn) ? (a < b)
             : ($signed(a) < $signed(b));
        e.res = {31'b0, lt};
      end
      3'd4: e.res = a ^ b;
      3'd5: e.res = o.arith ? 32'($signed(a) >>> sh)
                            : a >> sh;
      3'd6: e.res = a | b;
      default: e.res = a & b;
    endcase
    e.pci = o.pc + o.imm;
    case (o.f3)
      3'd0: cond = o.rs1 == o.rs2;
      3'd1: cond = o.rs1 != o.rs2;
      3'd4: cond = $signed(o.rs1) < $signed(o.rs2);
      3'd5: cond = $signed(o.rs1) >= $signed(o.rs2);
      3'd6: cond = o.rs1 < o.rs2;
      3'd7: cond = o.rs1 >= o.rs2;
      default: cond = 1'b0;
    endcase
    e.taken = o.jmp & (o.jt | cond);
    e.addr = o.jt ? {e.res[31:1], 1'b0} : e.pci;
    e.mis = e.taken & e.addr[1];
    if (o.div) begin
      e.taken = 1'b0;
      e.mis = 1'b0;
      if (o.rs2 == 0) begin
        q = 32'hFFFF_FFFF; r = o.rs1;
      end else if (!o.f3[0] && o.rs1 == 32'h8000_0000
                   && o.rs2 == 32'hFFFF_FFFF) begin
        q = o.rs1; r = 32'h0;
      end else if (!o.f3[0]) begin
        q = $signed(o.rs1) / $signed(o.rs2);
        r = $signed(o.rs1) % $signed(o.rs2);
      end else begin
        q = o.rs1 / o.rs2;
        r = o.rs1 % o.rs2;
      end
      e.res = o.f3[1] ? r : q;
    end
    return e;
  endfunction

  task automatic set_op(input op_t o);
    bus.i_alu_input_sel = o.isel;
    bus.i_alu_op_sel    = o.op;
    bus.i_alu_sub_sel   = o.sub;
    bus.i_alu_sign_sel  = o.sgn;
    bus.i_alu_arith_sel = o.arith;
    bus.i_div_sel       = o.div;
    bus.i_jump_sel      = o.jmp;
    bus.i_jump_type_sel = o.jt;
    bus.i_funct3        = o.f3;
    bus.i_rs1           = o.rs1;
    bus.i_rs2           = o.rs2;
    bus.i_immed         = o.imm;
    bus.i_pc            = o.pc;
  endtask

  // Issue one op, wait (bounded) for its result, compare
  task automatic run_op(input op_t o, input exp_t e,
                        input string nm);
    int lat;
    bit rdy_seen;
    @(negedge clk);
    set_op(o);
    bus.i_valid = 1'b1;
    lat = 0;
    while (!bus.o_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " ready"}, 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.o_valid && lat < 100) begin
      if (bus.o_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), o.div ? 32'd34 : 32'd1);
    chk({nm, " result"}, bus.o_result, e.res);
    if (o.div) begin
      chk({nm, " ready_stall"}, 32'(rdy_seen), 32'd0);
    end else begin
      chk({nm, " pc_immed"}, bus.o_pc_immed, e.pci);
      chk({nm, " taken"}, 32'(bus.o_jump_taken),
          32'(e.taken));
      chk({nm, " misalign"}, 32'(bus.o_misalign),
          32'(e.mis));
      if (o.jmp)
        chk({nm, " addr"}, bus.o_jump_addr, e.addr);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    op_t o;
    exp_t e;
    int cnt;
    logic [31:0] held;

    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    set_op('{default: '0});

    tbl.push_back('{"add", mk_alu(3'd0, 1, 0, 0, 0, 5, 0, 7),
                   ex(12, 0, 7, 0, 0)});
    tbl.push_back('{"sub", mk_alu(3'd0, 0, 1, 0, 0, 3, 5, 0),
                   ex(32'hFFFF_FFFE, 0, 0, 0, 0)});
    tbl.push_back('{"sra", mk_alu(3'd5, 1, 0, 0, 1,
                   32'h8000_0000, 0, 4),
                   ex(32'hF800_0000, 0, 4, 0, 0)});
    tbl.push_back('{"srl", mk_alu(3'd5, 1, 0, 0, 0,
                   32'h8000_0000, 0, 4),
                   ex(32'h0800_0000, 0, 4, 0, 0)});
    tbl.push_back('{"sll", mk_alu(3'd1, 1, 0, 0, 0, 1, 0, 31),
                   ex(32'h8000_0000, 0, 31, 0, 0)});
    tbl.push_back('{"slt", mk_alu(3'd2, 0, 0, 0, 0,
                   32'hFFFF_FFFF, 1, 0), ex(1, 0, 0, 0, 0)});
    tbl.push_back('{"sltu", mk_alu(3'd3, 0, 0, 0, 0,
                   32'hFFFF_FFFF, 1, 0), ex(0, 0, 0, 0, 0)});
    tbl.push_back('{"xor", mk_alu(3'd4, 0, 0, 0, 0,
                   32'hF0F0_F0F0, 32'hFF00_FF00, 0),
                   ex(32'h0FF0_0FF0, 0, 0, 0, 0)});
    tbl.push_back('{"blt", mk_br(3'b100, 0, 32'hFFFF_FFFF,
                   1, 32'h20, 32'h100),
                   ex(0, 32'h120, 32'h120, 1, 0)});
    tbl.push_back('{"bltu", mk_br(3'b110, 0, 32'hFFFF_FFFF,
                   1, 32'h20, 32'h100),
                   ex(0, 32'h120, 32'h120, 0, 0)});
    tbl.push_back('{"bge_mis", mk_br(3'b101, 0, 5, 5, 6,
                   32'h200), ex(10, 32'h206, 32'h206, 1, 1)});
    tbl.push_back('{"jalr", mk_br(3'b000, 1, 32'h1001, 0, 2,
                   32'h40), ex(32'h1003, 32'h1002, 32'h42, 1, 1)});
    tbl.push_back('{"div", mk_div(3'b100, -32'sd7, 2),
                   ex(32'hFFFF_FFFD, 0, 0, 0, 0)});
    tbl.push_back('{"rem", mk_div(3'b110, -32'sd7, 2),
                   ex(32'hFFFF_FFFF, 0, 0, 0, 0)});
    tbl.push_back('{"divu_z", mk_div(3'b101, 1234, 0),
                   ex(32'hFFFF_FFFF, 0, 0, 0, 0)});
    tbl.push_back('{"remu_z", mk_div(3'b111, 7, 0),
                   ex(7, 0, 0, 0, 0)});
    tbl.push_back('{"rem_ovf", mk_div(3'b110, 32'h8000_0000,
                   32'hFFFF_FFFF), ex(0, 0, 0, 0, 0)});
    tbl.push_back('{"div_ovf", mk_div(3'b100, 32'h8000_0000,
                   32'hFFFF_FFFF), ex(32'h8000_0000, 0, 0, 0, 0)});
    tbl.push_back('{"div_z", mk_div(3'b100, -32'sd5, 0),
                   ex(32'hFFFF_FFFF, 0, 0, 0, 0)});
    tbl.push_back('{"rem_z", mk_div(3'b110, -32'sd5, 0),
                   ex(32'hFFFF_FFFB, 0, 0, 0, 0)});
    tbl.push_back('{"divu", mk_div(3'b101, 100, 7),
                   ex(14, 0, 0, 0, 0)});
    tbl.push_back('{"remu", mk_div(3'b111, 100, 7),
                   ex(2, 0, 0, 0, 0)});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(bus.o_valid), 0);
    chk("rst result", bus.o_result, 0);
    chk("rst taken", 32'(bus.o_jump_taken), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'(bus.o_ready), 1);

    foreach (tbl[i]) run_op(tbl[i].o, tbl[i].e, tbl[i].nm);

    // Backpressure: outputs held, not ready
    @(negedge clk);
    bus.i_ready = 1'b0;
    set_op(mk_alu(3'd0, 1, 0, 0, 0, 1, 0, 2));
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("hold valid0", 32'(bus.o_valid), 1);
    chk("hold result0", bus.o_result, 3);
    held = bus.o_pc_immed;
    for (int k = 0; k < 3; k++) begin
      set_op(mk_alu(3'd4, 0, 0, 0, 0, $urandom, $urandom, 9));
      @(negedge clk);
      chk("hold valid", 32'(bus.o_valid), 1);
      chk("hold result", bus.o_result, 3);
      chk("hold pc_immed", bus.o_pc_immed, held);
      chk("hold ready", 32'(bus.o_ready), 0);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("drain valid", 32'(bus.o_valid), 0);

    // Flush in the middle of a divide
    set_op(mk_div(3'b100, 1000, 3));
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush valid", 32'(bus.o_valid), 0);
    chk("flush ready", 32'(bus.o_ready), 1);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_valid) cnt++;
    end
    chk("flush no result", 32'(cnt), 0);

    // Flush beats a simultaneous accept
    set_op(mk_alu(3'd0, 1, 0, 0, 0, 1, 0, 1));
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush+accept valid", 32'(bus.o_valid), 0);

    // Async reset during a divide
    run_op(tbl[0].o, tbl[0].e, "pre_rst");
    @(negedge clk);
    set_op(mk_div(3'b101, 77, 5));
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(bus.o_valid), 0);
    chk("arst result", bus.o_result, 0);
    chk("arst pc_immed", bus.o_pc_immed, 0);
    chk("arst ready", 32'(bus.o_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[13].o, tbl[13].e, "post_rst");

    // Random ops against the model
    for (int n = 0; n < 150; n++) begin
      o.isel  = 1'($urandom_range(0, 1));
      o.op    = 3'($urandom_range(0, 7));
      o.sub   = 1'($urandom_range(0, 1));
      o.sgn   = ($urandom_range(0, 3) == 0);
      o.arith = 1'($urandom_range(0, 1));
      o.div   = ($urandom_range(0, 7) == 0);
      o.jmp   = !o.div && ($urandom_range(0, 3) == 0);
      o.jt    = 1'($urandom_range(0, 1));
      o.f3    = o.div ? {1'b1, 2'($urandom_range(0, 3))}
                      : 3'($urandom_range(0, 7));
      o.rs1   = pick();
      o.rs2   = pick();
      o.imm   = $urandom_range(0, 1) ? pick()
                : 32'($urandom_range(0, 64));
      o.pc    = $urandom;
      e = model(o);
      run_op(o, e, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
